// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Sequencing FSM for the AES-128 round datapath. Walks the
//                load / initial add-round-key / middle rounds / final round
//                sequence for cipher or inverse cipher, driving stage select,
//                state-register enables and the round-key index, then holds
//                the result behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          decrypt,
    input  logic          abort,
    input  logic          out_ready,
    output logic          busy,
    output logic          ld_state,
    output logic          st_en,
    output logic [3:0]    stage_sel,
    output logic          inv,
    output logic [KW-1:0] key_idx,
    output logic [KW-1:0] round,
    output logic          out_valid
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_ark0  = 3'd2;
    localparam logic [2:0] c_st_mid   = 3'd3;
    localparam logic [2:0] c_st_final = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [3:0] c_sb  = 4'b0001;
    localparam logic [3:0] c_sr  = 4'b0010;
    localparam logic [3:0] c_mc  = 4'b0100;
    localparam logic [3:0] c_ark = 4'b1000;

    localparam logic [KW-1:0] c_nr  = KW'(NR);
    localparam logic [KW-1:0] c_one = KW'(1);

    logic [2:0]    r_state;
    logic [1:0]    r_stage;
    logic [KW-1:0] r_round;
    logic          r_inv;

    logic [2:0]    w_state_nxt;
    logic [1:0]    w_stage_nxt;
    logic [KW-1:0] w_round_nxt;
    logic          w_inv_nxt;
    logic [KW-1:0] w_round_inc;

    assign w_round_inc = r_round + c_one;

    // State register: FSM state, stage counter, round counter and latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_stage <= 2'd0;
            r_round <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_round <= w_round_nxt;
            r_inv   <= w_inv_nxt;
        end
    end

    // Next-state logic; abort outranks everything once an operation is live
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_round_nxt = r_round;
        w_inv_nxt   = r_inv;
        if (abort && (r_state != c_st_idle)) begin
            w_state_nxt = c_st_idle;
            w_stage_nxt = 2'd0;
            w_round_nxt = '0;
            w_inv_nxt   = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_state_nxt = c_st_load;
                        w_inv_nxt   = decrypt;
                    end
                end
                c_st_load: w_state_nxt = c_st_ark0;
                c_st_ark0: begin
                    w_state_nxt = c_st_mid;
                    w_stage_nxt = 2'd0;
                    w_round_nxt = c_one;
                end
                c_st_mid: begin
                    w_stage_nxt = r_stage + 2'd1;
                    if (r_stage == 2'd3) begin
                        w_round_nxt = w_round_inc;
                        if (w_round_inc == c_nr) begin
                            w_state_nxt = c_st_final;
                        end
                    end
                end
                c_st_final: begin
                    if (r_stage == 2'd2) begin
                        w_state_nxt = c_st_done;
                        w_stage_nxt = 2'd0;
                        w_round_nxt = '0;
                    end else begin
                        w_stage_nxt = r_stage + 2'd1;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        if (start) begin
                            w_state_nxt = c_st_load;
                            w_inv_nxt   = decrypt;
                        end else begin
                            w_state_nxt = c_st_idle;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_stage_nxt = 2'd0;
                    w_round_nxt = '0;
                    w_inv_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Moore output decode from registered state only
    always_comb begin
        busy      = (r_state != c_st_idle);
        ld_state  = 1'b0;
        st_en     = 1'b0;
        stage_sel = 4'b0000;
        inv       = r_inv;
        key_idx   = '0;
        round     = r_round;
        out_valid = 1'b0;
        case (r_state)
            c_st_load: ld_state = 1'b1;
            c_st_ark0: begin
                st_en     = 1'b1;
                stage_sel = c_ark;
                key_idx   = r_inv ? c_nr : '0;
            end
            c_st_mid: begin
                st_en   = 1'b1;
                key_idx = r_inv ? (c_nr - r_round) : r_round;
                case (r_stage)
                    2'd0:    stage_sel = r_inv ? c_sr  : c_sb;
                    2'd1:    stage_sel = r_inv ? c_sb  : c_sr;
                    2'd2:    stage_sel = r_inv ? c_ark : c_mc;
                    default: stage_sel = r_inv ? c_mc  : c_ark;
                endcase
            end
            c_st_final: begin
                st_en   = 1'b1;
                key_idx = r_inv ? '0 : c_nr;
                case (r_stage)
                    2'd0:    stage_sel = r_inv ? c_sr : c_sb;
                    2'd1:    stage_sel = r_inv ? c_sb : c_sr;
                    default: stage_sel = c_ark;
                endcase
            end
            c_st_done: out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Directed self-checking bench for aes_round_ctrl (NR=10):
//                encrypt/decrypt sequences, result hold, back-to-back,
//                abort, ignored start and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam int c_nr = 10;
    localparam int c_kw = 4;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            decrypt;
    logic            abort;
    logic            out_ready;
    logic            busy;
    logic            ld_state;
    logic            st_en;
    logic [3:0]      stage_sel;
    logic            inv;
    logic [c_kw-1:0] key_idx;
    logic [c_kw-1:0] round;
    logic            out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    aes_round_ctrl #(.NR(c_nr), .KW(c_kw)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .decrypt   (decrypt),
        .abort     (abort),
        .out_ready (out_ready),
        .busy      (busy),
        .ld_state  (ld_state),
        .st_en     (st_en),
        .stage_sel (stage_sel),
        .inv       (inv),
        .key_idx   (key_idx),
        .round     (round),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {busy, ld_state, st_en, stage_sel, inv, key_idx, round, out_valid}
    function automatic logic [16:0] act_vec();
        return {busy, ld_state, st_en, stage_sel, inv, key_idx, round, out_valid};
    endfunction

    // Expected outputs k cycles after the start-accepting edge (k=41 is DONE)
    function automatic logic [16:0] exp_vec(input bit dec, input int k);
        logic       b, l, s, ov;
        logic [3:0] sel, key, rnd;
        int         m, r, st;
        b = 1'b1; l = 1'b0; s = 1'b0; ov = 1'b0;
        sel = 4'd0; key = 4'd0; rnd = 4'd0;
        if (k == 0) begin
            l = 1'b1;
        end else if (k == 1) begin
            s = 1'b1; sel = 4'b1000; key = dec ? 4'd10 : 4'd0;
        end else if (k <= 37) begin
            m = k - 2; r = 1 + m / 4; st = m % 4;
            s = 1'b1; rnd = 4'(r);
            key = dec ? 4'(10 - r) : 4'(r);
            if (dec) sel = (st == 0) ? 4'b0010 : (st == 1) ? 4'b0001 : (st == 2) ? 4'b1000 : 4'b0100;
            else     sel = (st == 0) ? 4'b0001 : (st == 1) ? 4'b0010 : (st == 2) ? 4'b0100 : 4'b1000;
        end else if (k <= 40) begin
            st = k - 38;
            s = 1'b1; rnd = 4'd10; key = dec ? 4'd0 : 4'd10;
            if (st == 2)  sel = 4'b1000;
            else if (dec) sel = (st == 0) ? 4'b0010 : 4'b0001;
            else          sel = (st == 0) ? 4'b0001 : 4'b0010;
        end else begin
            ov = 1'b1;
        end
        return {b, l, s, sel, dec, key, rnd, ov};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present a start request for the next edge
    task automatic begin_op(input bit dec);
        start     = 1'b1;
        decrypt   = dec;
        out_ready = 1'b0;
    endtask

    // Check cycles 0..kstop; optionally toggle decrypt or pulse start mid-run
    task automatic walk(input bit dec, input int kstop, input int tog_k, input int pulse_k);
        for (int k = 0; k <= kstop; k++) begin
            @(negedge clk);
            check($sformatf("%s_k%0d", dec ? "dec" : "enc", k), 32'(act_vec()), 32'(exp_vec(dec, k)));
            if (k == 0) begin
                start     = 1'b0;
                out_ready = 1'b0;
            end
            if (k == tog_k)       decrypt = ~decrypt;
            if (k == pulse_k)     start = 1'b1;
            if (k == pulse_k + 1) start = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(act_vec()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(act_vec()), 32'd0);

        // Encrypt, then hold the result with out_ready low (start ignored)
        begin_op(1'b0);
        walk(1'b0, 41, -1, -1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            check($sformatf("hold_%0d", i), 32'(act_vec()), 32'(exp_vec(1'b0, 41)));
        end

        // Back-to-back decrypt; decrypt toggled mid-run, start pulsed in FINAL
        start = 1'b1; decrypt = 1'b1; out_ready = 1'b1;
        walk(1'b1, 41, 10, 38);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("dec_idle_busy", 32'(busy), 32'd0);
        check("dec_idle_valid", 32'(out_valid), 32'd0);
        check("dec_idle_sel", 32'(stage_sel), 32'd0);
        @(negedge clk);
        check("dec_idle_stay", 32'(busy), 32'd0);

        // Abort in decrypt MID round 3 MC stage together with start
        begin_op(1'b1);
        walk(1'b1, 13, -1, -1);
        abort = 1'b1; start = 1'b1; decrypt = 1'b1;
        @(negedge clk);
        check("abort_clear", 32'(act_vec()), 32'd0);
        abort = 1'b0;
        begin_op(1'b0);
        walk(1'b0, 41, -1, -1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_abort_idle", 32'(busy), 32'd0);

        // Asynchronous reset in MID round 5
        begin_op(1'b0);
        walk(1'b0, 18, -1, -1);
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(act_vec()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", 32'(act_vec()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencing FSM for the AES-128 round datapath (sub-bytes, shift-rows, mix-columns, add-round-key over a 4x32-bit row-organised state register).
- Accepts a start request and drives the per-cycle stage select, state-register load/write enables and round-key index through the full cipher or inverse cipher.
- Presents a valid/ready result handshake at the end.
- Sits between the host interface and the round datapath; owns no data itself.

Parameters:
- NR, 10, number of cipher rounds (10 for AES-128); legal range 2..14.
- KW, 4, width of round and key_idx counters; must satisfy 2^KW > NR.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new block operation; sampled when the block can accept
- decrypt  in  1  mode for the requested operation; sampled with an accepted start
- abort  in  1  synchronous cancel of the current operation
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE
- ld_state  out  1  load datapath state register from the input block
- st_en  out  1  write the datapath state register with the selected stage result
- stage_sel  out  4  one-hot stage select: [0] sub-bytes, [1] shift-rows, [2] mix-columns, [3] add-round-key
- inv  out  1  datapath uses inverse transforms; latched copy of decrypt
- key_idx  out  KW  round-key index presented to the key store
- round  out  KW  current round number, 0..NR
- out_valid  out  1  result in the state register is final

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and all outputs/registers to 0 (busy, ld_state, st_en, stage_sel, inv, key_idx, round, out_valid).
- Output timing: Moore-style. Every output decodes from registered state only; there is no combinational path from any input to any output.
- States: IDLE, LOAD, ARK0, MID, FINAL, DONE. MID and FINAL carry a 2-bit stage counter.
- IDLE:
  - start=1 latches decrypt into inv and moves to LOAD.
  - start=0 stays in IDLE.
- LOAD (1 cycle): ld_state=1, st_en=0, stage_sel=0. Next state ARK0.
- ARK0 (1 cycle): stage_sel=ARK, st_en=1, round=0, key_idx = 0 (encrypt) or NR (decrypt). Next state MID with round=1.
- MID (4 cycles per round, rounds 1..NR-1), st_en=1 on every cycle:
  - Encrypt order: SB, SR, MC, ARK; key_idx=round.
  - Decrypt order: SR, SB, ARK, MC; key_idx=NR-round.
  - After the 4th stage, round increments. When the new round equals NR, go to FINAL.
- FINAL (3 cycles, round=NR), st_en=1 on every cycle:
  - Encrypt order: SB, SR, ARK with key_idx=NR.
  - Decrypt order: SR, SB, ARK with key_idx=0.
  - Next state DONE.
- DONE: out_valid=1, st_en=0, stage_sel=0, busy=1. Holds until out_ready=1.
  - out_ready=1 and start=0: go to IDLE.
  - out_ready=1 and start=1: go directly to LOAD (back-to-back), re-latching inv from decrypt.
- Latency: start accepted at edge E implies 4*NR+1 active cycles. out_valid rises after edge E+4*NR+1 (E+41 for NR=10).
- Mode changes: decrypt is ignored except at start acceptance. start is ignored while busy, except in DONE with out_ready=1.
- abort=1 in any state: next state IDLE, all outputs cleared as at reset (inv cleared). abort has priority over start and out_ready. abort in IDLE has no effect.
- Counters: round and key_idx never wrap; both stay within 0..NR. Outside MID/FINAL/ARK0, round=0 and key_idx=0.
- stage_sel is all-zero whenever st_en=0. It is exactly one-hot whenever st_en=1.

Test Plan:
- Reset mid-operation: pulse rst_n low during MID round 5 -> all outputs 0 immediately (asynchronous); after release, IDLE with busy=0.
- Encrypt sequence: start=1, decrypt=0 at edge E -> ld_state for 1 cycle, then ARK key 0, then 9x(SB,SR,MC,ARK) with key_idx 1..9, then SB,SR,ARK key 10; out_valid at E+41; 40 st_en cycles total.
- Decrypt sequence: start=1, decrypt=1 -> ARK key 10, then rounds with order SR,SB,ARK,MC and key_idx 9 down to 1, then SR,SB,ARK key 0; inv=1 throughout; decrypt toggled mid-run has no effect.
- Result hold and back-to-back: keep out_ready=0 for 5 cycles after out_valid -> outputs frozen. Then out_ready=1 with start=1, decrypt=1 -> next cycle ld_state=1, inv=1, out_valid=0.
- Abort: assert abort in MID round 3 stage MC together with start=1 -> next cycle IDLE, busy=0, stage_sel=0, inv=0; start on the following cycle begins a fresh run with latency 41.
- Ignored start: pulse start during FINAL -> no effect on sequence; single out_valid; IDLE after out_ready.
